sccb_master: RTL and testbench

SCCB_MASTER -- requirements
Module: sccb_master

---
 rtl/sccb_master.sv | 172 +++++++++++++++++
 tb/tb_sccb_master.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_master.sv
// SCCB (camera-control bus) master. It issues 3-phase register writes and
// 2-phase-write + 2-phase-read register reads. All bus timing comes from one
// quarter-bit counter (qcnt) plus a quarter index (0..3).
`timescale 1ns/1ps

module sccb_master #(
  parameter logic [7:0] SLAVE_ADDR = 8'h60,
  parameter int         QDIV       = 128,
  parameter int         ADDR_BYTES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rw,
  input  logic [15:0] reg_addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        sio_c,
  inout  wire         sio_d
);

  typedef enum logic [2:0] {IDLE, START, SHIFT, STOP, GAP} state_t;

  localparam logic [11:0] Q_LAST  = 12'(QDIV - 1);
  // Index of the last byte in a write segment (address byte, register address, data)
  localparam logic [1:0]  WR_LAST = 2'(ADDR_BYTES + 1);
  // Index of the last byte in the first segment of a read (no data byte)
  localparam logic [1:0]  RD_LAST = 2'(ADDR_BYTES);

  state_t      state, state_next;
  logic [11:0] qcnt;
  logic [1:0]  quarter;
  logic [3:0]  bit_idx;
  logic [1:0]  byte_idx;
  logic        second_seg;
  logic        rw_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rx_shift;
  logic        accept;
  logic        q_end;
  logic        quarter_last;
  logic        last_byte;
  logic        read_phase;
  logic [7:0]  cur_byte;
  logic [2:0]  bit_sel;
  logic        d_oe;
  logic        d_out;

  // A request in the done cycle is refused so that done and busy never overlap a new job
  assign accept       = start && (state == IDLE) && !done;
  assign q_end        = (qcnt == Q_LAST);
  assign quarter_last = q_end && (quarter == 2'd3);
  // After the GAP only two bytes follow: the read address byte, then the byte we receive
  assign read_phase   = second_seg && (byte_idx == 2'd1);
  assign last_byte    = second_seg ? (byte_idx == 2'd1)
                                   : (byte_idx == (rw_q ? RD_LAST : WR_LAST));
  assign busy         = (state != IDLE);
  assign bit_sel      = 3'd7 - bit_idx[2:0];
  assign sio_d        = d_oe ? d_out : 1'bz;

  // Pick the byte being shifted out from the segment and the byte position inside it
  always_comb begin
    cur_byte = wdata_q;
    if (byte_idx == 2'd0)
      cur_byte = {SLAVE_ADDR[7:1], second_seg};
    else if (second_seg)
      cur_byte = 8'hFF;
    else if ((byte_idx == 2'd1) && (ADDR_BYTES == 2))
      cur_byte = addr_q[15:8];
    else if (byte_idx == RD_LAST)
      cur_byte = addr_q[7:0];
  end

  // Next-state decode and the bus pin levels for the current state and quarter
  always_comb begin
    state_next = state;
    sio_c      = 1'b1;
    d_oe       = 1'b0;
    d_out      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = START;
      end
      START: begin
        d_oe  = 1'b1;
        d_out = (quarter < 2'd2);
        if (quarter_last) state_next = SHIFT;
      end
      SHIFT: begin
        sio_c = (quarter == 2'd1) || (quarter == 2'd2);
        if (bit_idx == 4'd8) begin
          // Release for the slave's ACK on writes; drive NA (1) after the read byte
          d_oe  = read_phase;
          d_out = 1'b1;
        end else begin
          d_oe  = !read_phase;
          d_out = cur_byte[bit_sel];
        end
        if (quarter_last && (bit_idx == 4'd8) && last_byte) state_next = STOP;
      end
      STOP: begin
        sio_c = (quarter != 2'd0);
        d_oe  = (quarter < 2'd2);
        d_out = 1'b0;
        if (quarter_last) state_next = (rw_q && !second_seg) ? GAP : IDLE;
      end
      GAP: begin
        if (quarter_last) state_next = START;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, timing counters, latched request and the read shifter
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      qcnt       <= '0;
      quarter    <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      second_seg <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rx_shift   <= '0;
      rdata      <= '0;
      done       <= 1'b0;
    end else begin
      state <= state_next;
      done  <= busy && (state_next == IDLE);
      if (accept) begin
        rw_q       <= rw;
        addr_q     <= reg_addr;
        wdata_q    <= wdata;
        second_seg <= 1'b0;
        qcnt       <= '0;
        quarter    <= '0;
        bit_idx    <= '0;
        byte_idx   <= '0;
        rx_shift   <= '0;
      end else if (busy) begin
        if (q_end) begin
          qcnt    <= '0;
          quarter <= quarter + 2'd1;
        end else begin
          qcnt <= qcnt + 12'd1;
        end
        if ((state == SHIFT) && read_phase && (quarter == 2'd1) && q_end && (bit_idx != 4'd8))
          rx_shift <= {rx_shift[6:0], sio_d};
        if ((state == SHIFT) && quarter_last) begin
          if (bit_idx == 4'd8) begin
            bit_idx  <= '0;
            byte_idx <= byte_idx + 2'd1;
          end else begin
            bit_idx <= bit_idx + 4'd1;
          end
        end
        if ((state == STOP) && quarter_last) begin
          bit_idx  <= '0;
          byte_idx <= '0;
          if (state_next == GAP) second_seg <= 1'b1;
          if ((state_next == IDLE) && rw_q) rdata <= rx_shift;
        end
      end
    end
  end

endmodule

// File: tb/tb_sccb_master.sv
// Bench for sccb_master: two instances (1 and 2 register-address bytes) on their
// own pulled-up buses, a bus monitor/slave model, and a byte-level reference model.
`timescale 1ns/1ps

module tb_sccb_master;

  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        rw;
  logic [15:0] reg_addr;
  logic [7:0]  wdata;
  logic        sel;

  logic        busy_v  [2];
  logic        done_v  [2];
  logic [7:0]  rdata_v [2];
  logic        sioc_v  [2];
  logic        siod_v  [2];

  logic        obs_c, obs_d, obs_busy, obs_done;
  logic [7:0]  obs_rdata;

  logic        mon_clr;
  logic        slave_drv;
  logic [7:0]  sdata;
  logic [8:0]  got [$];
  int          n_start, n_stop, n_viol, n_done;

  int          checks = 0;
  int          errors = 0;

  always #20 clk = ~clk;

  // One bus per instance; the slave model only drives the bus of the selected instance
  for (genvar g = 0; g < 2; g++) begin : gb
    wire sio_d;
    pullup (sio_d);
    assign sio_d     = (slave_drv && (sel == 1'(g))) ? 1'b0 : 1'bz;
    assign siod_v[g] = sio_d;
    sccb_master #(
      .SLAVE_ADDR (g == 0 ? 8'h60 : 8'h61),
      .QDIV       (QD),
      .ADDR_BYTES (g + 1)
    ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start && (sel == 1'(g))),
      .rw       (rw),
      .reg_addr (reg_addr),
      .wdata    (wdata),
      .busy     (busy_v[g]),
      .done     (done_v[g]),
      .rdata    (rdata_v[g]),
      .sio_c    (sioc_v[g]),
      .sio_d    (sio_d)
    );
  end

  assign obs_c     = sioc_v[sel];
  assign obs_d     = siod_v[sel];
  assign obs_busy  = busy_v[sel];
  assign obs_done  = done_v[sel];
  assign obs_rdata = rdata_v[sel];

  // Bus monitor and slave: decodes 9-bit frames on sio_c rising edges, counts START/STOP,
  // flags data changes at a rising clock, ACKs write bytes and returns sdata on reads
  initial begin
    logic c, d, pc, pd;
    logic [8:0] sh;
    int redges, pos, byt;
    logic is_rd;
    pc = 1'b1; pd = 1'b1; sh = '0; redges = 0; is_rd = 1'b0;
    slave_drv = 1'b0;
    forever begin
      @(negedge clk);
      c = obs_c;
      d = obs_d;
      if (mon_clr) begin
        got.delete();
        n_start = 0; n_stop = 0; n_viol = 0; n_done = 0;
        redges = 0; is_rd = 1'b0; sh = '0; slave_drv = 1'b0;
      end else begin
        if (obs_done) n_done++;
        if (d != pd) begin
          if (c && pc) begin
            if (!d) begin
              n_start++; redges = 0; is_rd = 1'b0;
            end else begin
              n_stop++;
            end
          end else if (c) begin
            n_viol++;
          end
        end
        if (c && !pc) begin
          sh = {sh[7:0], d};
          redges++;
          if (redges == 8) is_rd = d;
          if (redges % 9 == 0) got.push_back(sh);
        end else if (!c && pc) begin
          pos = redges % 9;
          byt = redges / 9;
          if (is_rd && byt == 1) slave_drv = (pos < 8) ? !sdata[7 - pos] : 1'b0;
          else                   slave_drv = (pos == 8);
        end
      end
      pc = c;
      pd = d;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one transaction on the selected instance and checks it against the reference model.
  // pokes=1 adds a start pulse mid-transaction and another in the done cycle.
  task automatic applyStimulus(input bit rw_i, input logic [15:0] addr, input logic [7:0] wd,
                               input logic [7:0] sd, input bit pokes);
    logic [8:0] exp_bytes [$];
    int ab, q_total, exp_cyc, k, drops, n;
    logic [7:0] prev_rdata;

    ab = sel ? 2 : 1;
    exp_bytes.delete();
    exp_bytes.push_back({8'h60, 1'b0});
    if (ab == 2) exp_bytes.push_back({addr[15:8], 1'b0});
    exp_bytes.push_back({addr[7:0], 1'b0});
    if (!rw_i) begin
      exp_bytes.push_back({wd, 1'b0});
      q_total = 4 + 36 * (2 + ab) + 4;
    end else begin
      exp_bytes.push_back({8'h61, 1'b0});
      exp_bytes.push_back({sd, 1'b1});
      q_total = (4 + 36 * (1 + ab) + 4) + 4 + 4 + 72 + 4;
    end
    exp_cyc = QD * q_total + 1;

    prev_rdata = obs_rdata;
    mon_clr = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    mon_clr = 1'b0;
    sdata = sd; rw = rw_i; reg_addr = addr; wdata = wd;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_after_accept", obs_busy, 1);
    k = 1; drops = 0;
    while (!obs_done && k < 3000) begin
      if (!obs_busy) drops++;
      start    = pokes && (k == 150);
      rw       = 1'($urandom);
      reg_addr = 16'($urandom);
      wdata    = 8'($urandom);
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    checkOutput("done_latency", k, exp_cyc);
    checkOutput("busy_held", drops, 0);
    checkOutput("busy_in_done", obs_busy, 0);
    checkOutput("rdata_at_done", obs_rdata, rw_i ? sd : prev_rdata);
    if (pokes) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_after_done", obs_busy, 0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("idle_busy", obs_busy, 0);
    checkOutput("done_pulses", n_done, 1);
    checkOutput("rdata_hold", obs_rdata, rw_i ? sd : prev_rdata);
    checkOutput("starts", n_start, rw_i ? 2 : 1);
    checkOutput("stops", n_stop, rw_i ? 2 : 1);
    checkOutput("protocol", n_viol, 0);
    checkOutput("byte_count", got.size(), exp_bytes.size());
    n = (got.size() < exp_bytes.size()) ? got.size() : exp_bytes.size();
    for (int i = 0; i < n; i++) checkOutput($sformatf("frame%0d", i), got[i], exp_bytes[i]);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rw = 1'b0; reg_addr = '0; wdata = '0;
    sel = 1'b0; mon_clr = 1'b1; sdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_sio_c", obs_c, 1);
    checkOutput("rst_sio_d", obs_d, 1);
    checkOutput("rst_busy", obs_busy, 0);
    checkOutput("rst_done", obs_done, 0);
    checkOutput("rst_rdata", obs_rdata, 0);
    reset = 1'b0;
    mon_clr = 1'b0;

    // Directed cases on the single-address-byte instance
    sel = 1'b0;
    applyStimulus(1'b0, 16'h0012, 8'h80, 8'h00, 1'b0);
    applyStimulus(1'b0, 16'hA512, 8'h3C, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    applyStimulus(1'b1, 16'h000A, 8'h55, 8'h26, 1'b0);

    // Reset in Q50 of a write, with start held during the reset cycle
    mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
    rw = 1'b0; reg_addr = 16'h00C3; wdata = 8'h5A;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    checkOutput("pre_reset_busy", obs_busy, 1);
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    checkOutput("mid_rst_sio_c", obs_c, 1);
    checkOutput("mid_rst_sio_d", obs_d, 1);
    checkOutput("mid_rst_busy", obs_busy, 0);
    checkOutput("mid_rst_done", obs_done, 0);
    checkOutput("mid_rst_rdata", obs_rdata, 0);
    @(posedge clk); #1;
    checkOutput("mid_rst_idle", obs_busy, 0);
    applyStimulus(1'b0, 16'h0012, 8'h80, 8'h00, 1'b0);

    // Two-address-byte instance
    sel = 1'b1;
    applyStimulus(1'b0, 16'h3008, 8'h82, 8'h00, 1'b0);
    applyStimulus(1'b1, 16'h300A, 8'h00, 8'hC9, 1'b1);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
